// File: rtl/fetch_prefetch_queue_pkg.sv
// Purpose: shared constants and helpers for the fetch prefetch queue.
// Latency: n/a (no logic).
// Backpressure: n/a.
package fetch_prefetch_queue_pkg;

  localparam int INST_BYTES   = 4;
  localparam int PC_MAX_WIDTH = 64;

  typedef logic [PC_MAX_WIDTH-1:0] pc_max_t;

  // Instructions are word aligned; the low address bits are forced to zero.
  function automatic pc_max_t align_pc(input pc_max_t pc);
    return pc & ~pc_max_t'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Purpose: bundles the memory request/response port, control inputs and the
//          decode-facing valid/ready port of the fetch prefetch queue.
// Latency/backpressure: n/a (wires only); master = fetch unit, slave = environment.
interface fetch_prefetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  mem_req;      // fetch request valid
  logic [ADDR_WIDTH-1:0] mem_addr;     // word-aligned fetch address
  logic                  mem_gnt;      // request accepted this cycle
  logic                  mem_rsp_vld;  // in-order response valid
  logic [INST_WIDTH-1:0] mem_rsp_dat;  // fetched word
  logic                  hazard;       // MEM stage owns the memory port
  logic                  redirect;     // flush and restart at redirect_pc
  logic [ADDR_WIDTH-1:0] redirect_pc;  // new fetch PC
  logic                  dec_vld;      // head entry valid
  logic                  dec_rdy;      // decode consumes head
  logic [INST_WIDTH-1:0] dec_inst;     // head instruction
  logic [ADDR_WIDTH-1:0] dec_pc;       // head PC

  modport master (
    output mem_req, mem_addr, dec_vld, dec_inst, dec_pc,
    input  mem_gnt, mem_rsp_vld, mem_rsp_dat, hazard, redirect, redirect_pc, dec_rdy
  );

  modport slave (
    input  mem_req, mem_addr, dec_vld, dec_inst, dec_pc,
    output mem_gnt, mem_rsp_vld, mem_rsp_dat, hazard, redirect, redirect_pc, dec_rdy
  );
endinterface

// File: rtl/fetch_prefetch_queue_slot_ring.sv
// Purpose: DEPTH-entry slot ring with alloc/fill/head pointers and clear.
// Latency: fill to head_full visible 1 cycle later (registered flags).
// Backpressure: caller must not alloc when full; fill follows alloc order.
// Ports: clear flushes pointers; alloc_en/alloc_pc, fill_en/fill_dat, deq_en
//        drive the three pointers; head_* expose the oldest slot.
module fetch_slot_ring #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          clear,
  input  logic                          alloc_en,
  input  logic [ADDR_WIDTH-1:0]         alloc_pc,
  input  logic                          fill_en,
  input  logic [INST_WIDTH-1:0]         fill_dat,
  input  logic                          deq_en,
  output logic                          head_full,
  output logic [ADDR_WIDTH-1:0]         head_pc,
  output logic [INST_WIDTH-1:0]         head_inst,
  output logic [$clog2(DEPTH):0]        in_flight,
  output logic                          full
);
  localparam int IDXW = $clog2(DEPTH);
  localparam int PW   = IDXW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  full;
  } fetch_slot_t;

  fetch_slot_t   slots [DEPTH];
  logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr, used;

  // Pointers carry one extra wrap bit so used == DEPTH is distinguishable from 0.
  assign used      = alloc_ptr - head_ptr;
  assign in_flight = alloc_ptr - fill_ptr;
  assign full      = (used == PW'(DEPTH));

  assign head_full = slots[head_ptr[IDXW-1:0]].full;
  assign head_pc   = slots[head_ptr[IDXW-1:0]].pc;
  assign head_inst = slots[head_ptr[IDXW-1:0]].inst;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '{pc: RESET_PC, inst: '0, full: 1'b0};
      end
    end else if (clear) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i].full <= 1'b0;
      end
    end else begin
      if (alloc_en) begin
        slots[alloc_ptr[IDXW-1:0]].pc <= alloc_pc;
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (deq_en) begin
        slots[head_ptr[IDXW-1:0]].full <= 1'b0;
        head_ptr <= head_ptr + PW'(1);
      end
      if (fill_en) begin
        slots[fill_ptr[IDXW-1:0]].inst <= fill_dat;
        slots[fill_ptr[IDXW-1:0]].full <= 1'b1;
        fill_ptr <= fill_ptr + PW'(1);
      end
    end
  end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Purpose: fetch PC owner issuing pipelined imem requests into a DEPTH-slot prefetch queue.
// Latency: response to dec_vld 1 cycle; redirect to next request 1 cycle.
// Backpressure: dec_rdy stalls the head; request drops while the ring is full or hazard/redirect.
// Ports: i_clock, i_reset (sync, active high); bus = memory port, hazard/redirect
//        controls and decode valid/ready port (see fetch_prefetch_queue_if).
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  fetch_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc, redirect_pc_aligned, head_pc;
  logic [INST_WIDTH-1:0] head_inst;
  logic [PW-1:0]         drop_cnt, in_flight;
  logic                  ring_full, head_full, grant, rsp_drop, fill_en, deq_en;

  assign redirect_pc_aligned = ADDR_WIDTH'(align_pc(pc_max_t'(bus.redirect_pc)));

  // Full is registered ring state, so a same-cycle dequeue cannot re-open the request.
  assign bus.mem_req  = !i_reset && !bus.hazard && !bus.redirect && !ring_full;
  assign bus.mem_addr = fetch_pc;
  assign grant        = bus.mem_req && bus.mem_gnt;

  // Responses owed to squashed requests are consumed before any live slot fills.
  assign rsp_drop = (drop_cnt != '0);
  assign fill_en  = bus.mem_rsp_vld && !bus.redirect && !rsp_drop;
  assign deq_en   = head_full && bus.dec_rdy && !bus.redirect;

  assign bus.dec_vld  = head_full;
  assign bus.dec_inst = head_inst;
  assign bus.dec_pc   = head_pc;

  fetch_slot_ring #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) u_ring (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .clear     (bus.redirect),
    .alloc_en  (grant),
    .alloc_pc  (fetch_pc),
    .fill_en   (fill_en),
    .fill_dat  (bus.mem_rsp_dat),
    .deq_en    (deq_en),
    .head_full (head_full),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .in_flight (in_flight),
    .full      (ring_full)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      fetch_pc <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc <= redirect_pc_aligned;
    end else if (grant) begin
      fetch_pc <= fetch_pc + ADDR_WIDTH'(INST_BYTES);
    end
  end

  // On redirect every outstanding request becomes a drop. A response arriving in
  // that cycle answers the oldest outstanding request, whichever of drop_cnt or
  // in_flight currently accounts for it, so it is always taken off the total.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      drop_cnt <= '0;
    end else if (bus.redirect) begin
      drop_cnt <= drop_cnt + in_flight - PW'(bus.mem_rsp_vld);
    end else if (bus.mem_rsp_vld && rsp_drop) begin
      drop_cnt <= drop_cnt - PW'(1);
    end
  end

  // A response with nothing outstanding means the memory broke the protocol.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      assert (!(bus.mem_rsp_vld && drop_cnt == '0 && in_flight == '0));
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;
  localparam logic [31:0] MAGIC = 32'hA5A5_5A5A;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   lat_v    = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          chk;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[$];

  fetch_prefetch_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) mif ();

  fetch_prefetch_queue #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .DEPTH      (4),
    .RESET_PC   (32'h100)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle, plus an in-order memory model of configurable latency.
  task automatic step();
    logic g, r, rs;
    logic [31:0] a;
    @(negedge clk);
    g  = mif.mem_req && mif.mem_gnt;
    a  = mif.mem_addr;
    r  = mif.mem_rsp_vld;
    rs = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      mq.delete();
    end else begin
      if (r && mq.size() > 0) mq.delete(0);
      if (g) mq.push_back('{addr: a, due: cyc - 1 + lat_v});
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mif.mem_rsp_vld = 1'b1;
      mif.mem_rsp_dat = mq[0].addr ^ MAGIC;
    end else begin
      mif.mem_rsp_vld = 1'b0;
      mif.mem_rsp_dat = '0;
    end
  endtask

  task automatic do_reset(input int lat);
    lat_v            = lat;
    rst              = 1'b1;
    mif.redirect     = 1'b0;
    mif.redirect_pc  = '0;
    mif.hazard       = 1'b0;
    mif.mem_gnt      = 1'b1;
    mif.dec_rdy      = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Consumes with dec_rdy held high; every visible entry must continue the PC sequence.
  task automatic run_expect(input string nm, input logic [31:0] start, input int n,
                            input int first_off, input int min_vld);
    logic [31:0] e;
    int nv, first;
    e = start;
    nv = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      #1;
      if (mif.dec_vld) begin
        chk({nm, "_pc"}, mif.dec_pc, e);
        chk({nm, "_inst"}, mif.dec_inst, e ^ MAGIC);
        if (first < 0) first = i;
        nv++;
        e = e + 32'd4;
      end
      step();
    end
    if (first_off >= 0) chk({nm, "_first_vld_cycle"}, 32'(first), 32'(first_off));
    chk({nm, "_enough_vld"}, 32'(nv >= min_vld), 32'd1);
  endtask

  function automatic vec_t v(input bit r, input bit rd, input bit c, input bit rq,
                             input logic [31:0] ad, input bit vl, input logic [31:0] p);
    vec_t x;
    x = '{rst: r, rdy: rd, chk: c, req: rq, addr: ad, vld: vl, pc: p};
    return x;
  endfunction

  initial begin
    rst             = 1'b1;
    mif.mem_gnt     = 1'b1;
    mif.mem_rsp_vld = 1'b0;
    mif.mem_rsp_dat = '0;
    mif.hazard      = 1'b0;
    mif.redirect    = 1'b0;
    mif.redirect_pc = '0;
    mif.dec_rdy     = 1'b1;
    lat_v           = 1;

    // rst rdy chk req addr vld pc ; 1-cycle memory, always granted
    tbl.push_back(v(1, 1, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(v(1, 1, 1, 0, 32'h0,   0, 32'h100));
    tbl.push_back(v(0, 1, 1, 1, 32'h100, 0, 32'h0));
    tbl.push_back(v(0, 1, 1, 1, 32'h104, 0, 32'h0));
    tbl.push_back(v(0, 1, 1, 1, 32'h108, 1, 32'h100));
    tbl.push_back(v(0, 1, 1, 1, 32'h10C, 1, 32'h104));
    tbl.push_back(v(0, 1, 1, 1, 32'h110, 1, 32'h108));
    tbl.push_back(v(0, 1, 1, 1, 32'h114, 1, 32'h10C));
    // reset mid-stream, then fill the queue with decode stalled
    tbl.push_back(v(1, 1, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(v(1, 0, 1, 0, 32'h0,   0, 32'h100));
    tbl.push_back(v(0, 0, 1, 1, 32'h100, 0, 32'h0));
    tbl.push_back(v(0, 0, 1, 1, 32'h104, 0, 32'h0));
    tbl.push_back(v(0, 0, 1, 1, 32'h108, 1, 32'h100));
    tbl.push_back(v(0, 0, 1, 1, 32'h10C, 1, 32'h100));
    tbl.push_back(v(0, 0, 1, 0, 32'h0,   1, 32'h100));
    tbl.push_back(v(0, 0, 1, 0, 32'h0,   1, 32'h100));
    tbl.push_back(v(0, 1, 1, 0, 32'h0,   1, 32'h100));
    tbl.push_back(v(0, 1, 1, 1, 32'h110, 1, 32'h104));
    tbl.push_back(v(0, 1, 1, 1, 32'h114, 1, 32'h108));
    tbl.push_back(v(0, 1, 1, 1, 32'h118, 1, 32'h10C));
    tbl.push_back(v(0, 1, 1, 1, 32'h11C, 1, 32'h110));

    for (int i = 0; i < tbl.size(); i++) begin
      rst         = tbl[i].rst;
      mif.dec_rdy = tbl[i].rdy;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("t%0d_req", i), 32'(mif.mem_req), 32'(tbl[i].req));
        if (tbl[i].req) chk($sformatf("t%0d_addr", i), mif.mem_addr, tbl[i].addr);
        chk($sformatf("t%0d_vld", i), 32'(mif.dec_vld), 32'(tbl[i].vld));
        if (tbl[i].vld || tbl[i].rst) chk($sformatf("t%0d_pc", i), mif.dec_pc, tbl[i].pc);
        if (tbl[i].rst) chk($sformatf("t%0d_inst_rst", i), mif.dec_inst, 32'h0);
        else if (tbl[i].vld) chk($sformatf("t%0d_inst", i), mif.dec_inst, tbl[i].pc ^ MAGIC);
      end
      step();
    end

    // 3-cycle memory, three in flight, redirect to an unaligned target.
    do_reset(3);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("s3_req_k%0d", k), 32'(mif.mem_req), 32'd1);
      chk($sformatf("s3_addr_k%0d", k), mif.mem_addr, 32'h100 + 32'(4 * k));
      step();
    end
    mif.redirect    = 1'b1;
    mif.redirect_pc = 32'h2002;
    #1;
    chk("s3_req_during_redirect", 32'(mif.mem_req), 32'd0);
    step();
    mif.redirect = 1'b0;
    #1;
    chk("s3_req_after_redirect", 32'(mif.mem_req), 32'd1);
    chk("s3_addr_after_redirect", mif.mem_addr, 32'h2000);
    run_expect("s3", 32'h2000, 10, 4, 4);

    // Redirect on a response cycle, then a second redirect the next cycle.
    do_reset(3);
    step();
    mif.mem_gnt = 1'b0;
    step();
    mif.mem_gnt = 1'b1;
    step();
    mif.redirect    = 1'b1;
    mif.redirect_pc = 32'h3000;
    #1;
    chk("s4_vld_redirect1", 32'(mif.dec_vld), 32'd0);
    step();
    mif.redirect_pc = 32'h4000;
    #1;
    chk("s4_vld_redirect2", 32'(mif.dec_vld), 32'd0);
    step();
    mif.redirect = 1'b0;
    #1;
    chk("s4_addr_after", mif.mem_addr, 32'h4000);
    run_expect("s4", 32'h4000, 10, 4, 4);

    // Hazard for 5 cycles with two requests in flight.
    do_reset(3);
    step();
    step();
    mif.hazard  = 1'b1;
    mif.dec_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("s5_req_hazard_%0d", k), 32'(mif.mem_req), 32'd0);
      if (k == 4) begin
        chk("s5_vld_buffered", 32'(mif.dec_vld), 32'd1);
        chk("s5_pc_buffered", mif.dec_pc, 32'h100);
      end
      step();
    end
    mif.hazard  = 1'b0;
    mif.dec_rdy = 1'b1;
    #1;
    chk("s5_req_resume", 32'(mif.mem_req), 32'd1);
    chk("s5_addr_resume", mif.mem_addr, 32'h108);
    run_expect("s5", 32'h100, 10, 0, 4);

    // Fetch address wraps from the top of the address space.
    do_reset(1);
    mif.redirect    = 1'b1;
    mif.redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("s6_req_redirect", 32'(mif.mem_req), 32'd0);
    step();
    mif.redirect = 1'b0;
    #1;
    chk("s6_addr_top", mif.mem_addr, 32'hFFFF_FFFC);
    step();
    #1;
    chk("s6_req_wrap", 32'(mif.mem_req), 32'd1);
    chk("s6_addr_wrap", mif.mem_addr, 32'h0000_0000);
    run_expect("s6", 32'hFFFF_FFFC, 6, 1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
